// File: rtl/hazard_check_unit.sv
// Scoreboard-based RAW/WAW hazard check ahead of the index stage.
// Tracks in-flight destinations and hands out issue numbers that the commit path frees again.
module hazard_check_unit #(
  parameter int NUM_ENTRY_HAZARD   = 8,
  parameter int WIDTH_ENTRY_HAZARD = $clog2(NUM_ENTRY_HAZARD),
  parameter int WIDTH_INDEX        = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          I_Req,
  input  logic                          I_Dst_V,
  input  logic [WIDTH_INDEX:0]          I_Dst,
  input  logic                          I_Src1_V,
  input  logic                          I_Src2_V,
  input  logic                          I_Src3_V,
  input  logic [WIDTH_INDEX:0]          I_Src1,
  input  logic [WIDTH_INDEX:0]          I_Src2,
  input  logic [WIDTH_INDEX:0]          I_Src3,
  output logic                          O_Ready,
  output logic                          O_Issue,
  output logic [WIDTH_ENTRY_HAZARD-1:0] O_Issue_No,
  input  logic                          I_Commit,
  input  logic [WIDTH_ENTRY_HAZARD-1:0] I_Commit_No,
  output logic                          O_Full,
  output logic                          O_Empty,
  output logic [WIDTH_ENTRY_HAZARD:0]   O_Count
);

  logic [NUM_ENTRY_HAZARD-1:0]   valid_q, valid_d;
  logic [NUM_ENTRY_HAZARD-1:0]   dst_v_q, dst_v_d;
  logic [WIDTH_INDEX:0]          dst_q [NUM_ENTRY_HAZARD];
  logic [WIDTH_INDEX:0]          dst_d [NUM_ENTRY_HAZARD];
  logic [WIDTH_ENTRY_HAZARD:0]   count_q, count_d;
  logic                          issue_q, issue_d;
  logic [WIDTH_ENTRY_HAZARD-1:0] issue_no_q, issue_no_d;

  logic                          raw, waw, full;
  logic                          alloc_found;
  logic [WIDTH_ENTRY_HAZARD-1:0] alloc_no;
  logic                          accept, commit_eff;

  // Hazards look only at registered table state, so a same-cycle commit never unblocks.
  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    for (int unsigned i = 0; i < NUM_ENTRY_HAZARD; i++) begin
      if (valid_q[i] && dst_v_q[i]) begin
        if (I_Src1_V && (I_Src1 == dst_q[i])) raw = 1'b1;
        if (I_Src2_V && (I_Src2 == dst_q[i])) raw = 1'b1;
        if (I_Src3_V && (I_Src3 == dst_q[i])) raw = 1'b1;
        if (I_Dst_V  && (I_Dst  == dst_q[i])) waw = 1'b1;
      end
    end
  end

  always_comb begin
    alloc_found = 1'b0;
    alloc_no    = '0;
    for (int unsigned i = 0; i < NUM_ENTRY_HAZARD; i++) begin
      if (!valid_q[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_no    = WIDTH_ENTRY_HAZARD'(i);
      end
    end
  end

  assign full       = &valid_q;
  assign O_Ready    = !full && !raw && !waw;
  assign accept     = I_Req && O_Ready;
  assign commit_eff = I_Commit && valid_q[I_Commit_No];

  always_comb begin
    valid_d    = valid_q;
    dst_v_d    = dst_v_q;
    dst_d      = dst_q;
    count_d    = count_q;
    issue_d    = accept;
    issue_no_d = issue_no_q;

    if (commit_eff) begin
      valid_d[I_Commit_No] = 1'b0;
    end

    // The allocated slot is free before the edge, so it never collides with the commit slot.
    if (accept) begin
      valid_d[alloc_no] = 1'b1;
      dst_v_d[alloc_no] = I_Dst_V;
      dst_d[alloc_no]   = I_Dst;
      issue_no_d        = alloc_no;
    end

    case ({accept, commit_eff})
      2'b10:   count_d = count_q + (WIDTH_ENTRY_HAZARD+1)'(1);
      2'b01:   count_d = count_q - (WIDTH_ENTRY_HAZARD+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= '0;
      dst_v_q    <= '0;
      dst_q      <= '{default: '0};
      count_q    <= '0;
      issue_q    <= 1'b0;
      issue_no_q <= '0;
    end else begin
      valid_q    <= valid_d;
      dst_v_q    <= dst_v_d;
      dst_q      <= dst_d;
      count_q    <= count_d;
      issue_q    <= issue_d;
      issue_no_q <= issue_no_d;
    end
  end

  assign O_Issue    = issue_q;
  assign O_Issue_No = issue_no_q;
  assign O_Full     = full;
  assign O_Empty    = ~|valid_q;
  assign O_Count    = count_q;

endmodule

// File: tb/tb_hazard_check_unit.sv
// Directed bench for hazard_check_unit: expected issue numbers go into a queue
// and a negedge monitor matches them against O_Issue/O_Issue_No and their cycle.
module tb_hazard_check_unit;

  logic       clock;
  logic       reset;
  logic       I_Req;
  logic       I_Dst_V;
  logic [6:0] I_Dst;
  logic       I_Src1_V, I_Src2_V, I_Src3_V;
  logic [6:0] I_Src1, I_Src2, I_Src3;
  logic       O_Ready;
  logic       O_Issue;
  logic [2:0] O_Issue_No;
  logic       I_Commit;
  logic [2:0] I_Commit_No;
  logic       O_Full;
  logic       O_Empty;
  logic [3:0] O_Count;

  hazard_check_unit #(
    .NUM_ENTRY_HAZARD(8),
    .WIDTH_INDEX(6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .I_Req(I_Req),
    .I_Dst_V(I_Dst_V),
    .I_Dst(I_Dst),
    .I_Src1_V(I_Src1_V),
    .I_Src2_V(I_Src2_V),
    .I_Src3_V(I_Src3_V),
    .I_Src1(I_Src1),
    .I_Src2(I_Src2),
    .I_Src3(I_Src3),
    .O_Ready(O_Ready),
    .O_Issue(O_Issue),
    .O_Issue_No(O_Issue_No),
    .I_Commit(I_Commit),
    .I_Commit_No(I_Commit_No),
    .O_Full(O_Full),
    .O_Empty(O_Empty),
    .O_Count(O_Count)
  );

  typedef struct {
    int         cyc;
    logic [2:0] no;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every O_Issue must match the queue head in both cycle and issue number.
  always @(negedge clock) begin
    if (!reset) begin
      if (O_Issue) begin
        checks = checks + 1;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          errors = errors + 1;
          $display("FAIL issue_timing: got O_Issue (no %0d) at cycle %0d expected no issue", O_Issue_No, cyc);
          if (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (O_Issue_No !== e.no) begin
            errors = errors + 1;
            $display("FAIL issue_no: got %0d expected %0d at cycle %0d", O_Issue_No, e.no, cyc);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL issue_missing: got O_Issue=0 expected issue no %0d at cycle %0d", e.no, cyc);
      end
    end
  end

  task automatic set_idle();
    I_Req    = 1'b0;
    I_Dst_V  = 1'b0;
    I_Dst    = '0;
    I_Src1_V = 1'b0;
    I_Src2_V = 1'b0;
    I_Src3_V = 1'b0;
    I_Src1   = '0;
    I_Src2   = '0;
    I_Src3   = '0;
  endtask

  task automatic set_req(input logic dv, input logic [6:0] d,
                         input logic s1v, input logic [6:0] s1,
                         input logic s2v, input logic [6:0] s2,
                         input logic s3v, input logic [6:0] s3);
    I_Req    = 1'b1;
    I_Dst_V  = dv;
    I_Dst    = d;
    I_Src1_V = s1v;
    I_Src1   = s1;
    I_Src2_V = s2v;
    I_Src2   = s2;
    I_Src3_V = s3v;
    I_Src3   = s3;
  endtask

  task automatic set_commit(input logic c, input logic [2:0] no);
    I_Commit    = c;
    I_Commit_No = no;
  endtask

  // One cycle: check state at negedge, queue the expected issue if accepted, advance past the edge.
  task automatic tick(input logic exp_rdy, input logic [2:0] exp_no, input int exp_cnt, input string name);
    @(negedge clock);
    check({name, " O_Ready"}, {31'd0, O_Ready}, {31'd0, exp_rdy});
    check({name, " O_Count"}, {28'd0, O_Count}, exp_cnt);
    check({name, " O_Full"},  {31'd0, O_Full},  {31'd0, exp_cnt == 8});
    check({name, " O_Empty"}, {31'd0, O_Empty}, {31'd0, exp_cnt == 0});
    if (I_Req && exp_rdy && !reset) exp_q.push_back('{cyc + 1, exp_no});
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    set_commit(1'b0, 3'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    @(negedge clock);
    check("reset O_Issue",    {31'd0, O_Issue},    32'd0);
    check("reset O_Issue_No", {29'd0, O_Issue_No}, 32'd0);
    check("reset O_Count",    {28'd0, O_Count},    32'd0);
    check("reset O_Full",     {31'd0, O_Full},     32'd0);
    check("reset O_Empty",    {31'd0, O_Empty},    32'd1);
    check("reset O_Ready",    {31'd0, O_Ready},    32'd1);
    @(posedge clock);
    #1;

    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 7'(i + 1), 1'b0, '0, 1'b0, '0, 1'b0, '0);
      tick(1'b1, 3'(i), i, "fill");
    end
    set_req(1'b1, 7'd9, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    tick(1'b0, 3'd0, 8, "full stall");

    set_req(1'b1, 7'd10, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    set_commit(1'b1, 3'd3);
    tick(1'b0, 3'd0, 8, "full+commit");
    set_commit(1'b0, 3'd0);
    tick(1'b1, 3'd3, 7, "accept after commit");
    set_idle();
    tick(1'b0, 3'd0, 8, "refilled");

    set_commit(1'b1, 3'd6);
    tick(1'b0, 3'd0, 8, "commit 6");
    tick(1'b1, 3'd0, 7, "commit 6 again");
    set_commit(1'b0, 3'd0);
    tick(1'b1, 3'd0, 7, "invalid commit ignored");

    set_req(1'b1, 7'd20, 1'b1, 7'd5, 1'b0, '0, 1'b0, '0);
    tick(1'b0, 3'd0, 7, "raw src1");
    set_req(1'b1, 7'd20, 1'b0, '0, 1'b1, 7'd5, 1'b0, '0);
    tick(1'b0, 3'd0, 7, "raw src2");
    set_req(1'b1, 7'd20, 1'b0, '0, 1'b0, '0, 1'b1, 7'd8);
    tick(1'b0, 3'd0, 7, "raw src3");
    set_req(1'b1, 7'd20, 1'b1, 7'd5, 1'b0, '0, 1'b0, '0);
    set_commit(1'b1, 3'd4);
    tick(1'b0, 3'd0, 7, "raw no bypass");
    set_commit(1'b0, 3'd0);
    tick(1'b1, 3'd4, 6, "raw release");

    set_req(1'b1, 7'h03, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    tick(1'b0, 3'd0, 7, "waw");
    set_req(1'b1, 7'h43, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    tick(1'b1, 3'd6, 7, "waw other file");
    set_idle();
    set_commit(1'b1, 3'd0);
    tick(1'b0, 3'd0, 8, "commit 0");

    set_req(1'b0, 7'h02, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    set_commit(1'b1, 3'd1);
    tick(1'b1, 3'd0, 7, "dst_v0 accept");
    set_commit(1'b0, 3'd0);
    set_req(1'b1, 7'h31, 1'b1, 7'h02, 1'b1, 7'h48, 1'b1, 7'h31);
    tick(1'b1, 3'd1, 7, "reader not blocked");

    set_req(1'b1, 7'h32, 1'b1, 7'h03, 1'b0, '0, 1'b0, '0);
    tick(1'b0, 3'd0, 8, "stalled raw");
    reset = 1'b1;
    set_commit(1'b1, 3'd2);
    tick(1'b0, 3'd0, 8, "reset cycle");
    reset = 1'b0;
    set_commit(1'b0, 3'd0);
    tick(1'b1, 3'd0, 0, "after reset");
    set_idle();
    tick(1'b1, 3'd0, 1, "post-reset count");
    tick(1'b1, 3'd0, 1, "drain");
    tick(1'b1, 3'd0, 1, "drain");

    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
